// File: rtl/ft_pkg.sv
// Shared definitions for the FT600 streaming path: bus width, default frame
// sync word and the frame FSM state encoding.
package ft_pkg;

  localparam int          FT_DATA_WIDTH     = 32;
  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A55A5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR0    = 2'd1,
    ST_HDR1    = 2'd2,
    ST_PAYLOAD = 2'd3
  } frame_state_t;

endpackage

// File: rtl/iq_pair_packer.sv
// Pairs consecutive complex samples into one 32-bit word {Q1,I1,Q0,I0}.
// The completed word is presented combinationally in the cycle the second
// sample arrives, so the caller can register it with one cycle of latency.
module iq_pair_packer
  import ft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [7:0]               in_i,
  input  logic [7:0]               in_q,
  output logic                     out_valid,
  output logic [FT_DATA_WIDTH-1:0] out_word
);

  logic [15:0] r_half;
  logic        r_half_vld;

  // Half-word occupancy: filled by the first sample of a pair, emptied by the second or by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_half_vld <= 1'b0;
    end else if (clear) begin
      r_half_vld <= 1'b0;
    end else if (in_valid) begin
      r_half_vld <= ~r_half_vld;
    end
  end

  // Half-word data: captures sample 0 of a pair; meaningful only while r_half_vld is set.
  always_ff @(posedge clk) begin
    if (in_valid && !r_half_vld) begin
      r_half <= {in_q, in_i};
    end
  end

  assign out_valid = in_valid && r_half_vld && !clear;
  assign out_word  = {in_q, in_i, r_half};

endmodule

// File: rtl/iq_sample_packer.sv
// Packs I/Q sample pairs into 32-bit words and frames them (sync word,
// {sequence, drop count} header, FRAME_WORDS payload words) onto the write
// side of the A2F FIFO. Payload words meeting a full FIFO are dropped and
// counted; header words wait for space instead.
module iq_sample_packer
  import ft_pkg::*;
#(
  parameter int          FT_DATA_WIDTH = ft_pkg::FT_DATA_WIDTH,
  parameter int          FRAME_WORDS   = 1024,
  parameter logic [31:0] SYNC_WORD     = ft_pkg::SYNC_WORD_DEFAULT
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [7:0]               sample_i,
  input  logic [7:0]               sample_q,
  input  logic                     fifo_full,
  output logic                     fifo_wr_req,
  output logic [FT_DATA_WIDTH-1:0] fifo_wdata,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              frame_seq
);

  frame_state_t             r_state;
  logic                     r_wr_req;
  logic [FT_DATA_WIDTH-1:0] r_wdata;
  logic [15:0]              r_drop;
  logic [15:0]              r_seq;
  logic [16:0]              r_pay_cnt;
  logic [FT_DATA_WIDTH-1:0] r_hold;
  logic                     r_hold_vld;

  frame_state_t             w_state_nxt;
  logic                     w_wr_nxt;
  logic [FT_DATA_WIDTH-1:0] w_wdata_nxt;
  logic [15:0]              w_drop_nxt;
  logic [15:0]              w_seq_nxt;
  logic [16:0]              w_pay_nxt;
  logic [FT_DATA_WIDTH-1:0] w_hold_nxt;
  logic                     w_hold_vld_nxt;
  logic [1:0]               w_n_drop;
  logic [1:0]               w_n_words;
  logic [16:0]              w_pay_sum;
  logic [FT_DATA_WIDTH-1:0] w_out_word;

  logic                     w_pk_clear;
  logic                     w_pk_in_vld;
  logic                     w_cmp_vld;
  logic [FT_DATA_WIDTH-1:0] w_cmp_word;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Samples only count while streaming; leaving IDLE or disabling drops any half pair.
  assign w_pk_clear  = !enable || (r_state == ST_IDLE);
  assign w_pk_in_vld = sample_valid && !w_pk_clear;

  iq_pair_packer u_pair (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_pk_clear),
    .in_valid  (w_pk_in_vld),
    .in_i      (sample_i),
    .in_q      (sample_q),
    .out_valid (w_cmp_vld),
    .out_word  (w_cmp_word)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus write/hold/counter decisions for the current cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_nxt       = 1'b0;
    w_wdata_nxt    = r_wdata;
    w_drop_nxt     = r_drop;
    w_seq_nxt      = r_seq;
    w_pay_nxt      = r_pay_cnt;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_n_drop       = 2'd0;
    w_n_words      = 2'd0;
    w_pay_sum      = r_pay_cnt;
    w_out_word     = r_hold;

    if (!enable) begin
      // Abandon everything in flight; an interrupted payload still consumes a sequence number.
      w_state_nxt    = ST_IDLE;
      w_hold_vld_nxt = 1'b0;
      if (r_state == ST_PAYLOAD) begin
        w_seq_nxt = r_seq + 16'd1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_HDR0;
        end
        ST_HDR0, ST_HDR1: begin
          // Completions during the header park in the hold slot; a second one has nowhere to go.
          if (w_cmp_vld) begin
            if (r_hold_vld) begin
              w_n_drop = 2'd1;
            end else begin
              w_hold_nxt     = w_cmp_word;
              w_hold_vld_nxt = 1'b1;
            end
          end
          w_drop_nxt = sat_add16(r_drop, w_n_drop);
          if (!fifo_full) begin
            w_wr_nxt = 1'b1;
            if (r_state == ST_HDR0) begin
              w_wdata_nxt = SYNC_WORD;
              w_state_nxt = ST_HDR1;
            end else begin
              w_wdata_nxt = {r_seq, r_drop};
              w_drop_nxt  = {14'd0, w_n_drop};
              w_pay_nxt   = '0;
              w_state_nxt = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          // The held word leaves first; a completion colliding with it is lost.
          if (r_hold_vld) begin
            w_out_word     = r_hold;
            w_hold_vld_nxt = 1'b0;
            w_n_words      = w_cmp_vld ? 2'd2 : 2'd1;
            w_n_drop       = w_cmp_vld ? 2'd1 : 2'd0;
          end else begin
            w_out_word = w_cmp_word;
            w_n_words  = w_cmp_vld ? 2'd1 : 2'd0;
          end
          if (w_n_words != 2'd0) begin
            if (fifo_full) begin
              w_n_drop = w_n_drop + 2'd1;
            end else begin
              w_wr_nxt    = 1'b1;
              w_wdata_nxt = w_out_word;
            end
          end
          w_drop_nxt = sat_add16(r_drop, w_n_drop);
          w_pay_sum  = r_pay_cnt + {15'd0, w_n_words};
          if ((w_n_words != 2'd0) && (w_pay_sum >= 17'(FRAME_WORDS))) begin
            w_state_nxt = ST_HDR0;
            w_seq_nxt   = r_seq + 16'd1;
            w_pay_nxt   = '0;
          end else begin
            w_pay_nxt = w_pay_sum;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_req   <= 1'b0;
      r_wdata    <= '0;
      r_drop     <= '0;
      r_seq      <= '0;
      r_pay_cnt  <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_wr_req   <= w_wr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_drop     <= w_drop_nxt;
      r_seq      <= w_seq_nxt;
      r_pay_cnt  <= w_pay_nxt;
      r_hold_vld <= w_hold_vld_nxt;
    end
  end

  // Hold slot data; qualified by r_hold_vld.
  always_ff @(posedge clk) begin
    r_hold <= w_hold_nxt;
  end

  assign fifo_wr_req = r_wr_req;
  assign fifo_wdata  = r_wdata;
  assign drop_cnt    = r_drop;
  assign frame_seq   = r_seq;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Directed bench for iq_sample_packer: one short-frame instance (4 words)
// and one longer-frame instance (16 words) share the same stimulus.
module tb_iq_sample_packer;

  localparam logic [31:0] SYNC = 32'hA5A55A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [7:0]  sample_i;
  logic [7:0]  sample_q;
  logic        fifo_full;

  logic        a_wr, b_wr;
  logic [31:0] a_wdata, b_wdata;
  logic [15:0] a_drop, b_drop, a_seq, b_seq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];
  int          viol_a = 0;
  int          viol_b = 0;
  logic        prev_full = 1'b0;

  iq_sample_packer #(.FRAME_WORDS(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .fifo_full(fifo_full),
    .fifo_wr_req(a_wr), .fifo_wdata(a_wdata), .drop_cnt(a_drop), .frame_seq(a_seq)
  );

  iq_sample_packer #(.FRAME_WORDS(16)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .fifo_full(fifo_full),
    .fifo_wr_req(b_wr), .fifo_wdata(b_wdata), .drop_cnt(b_drop), .frame_seq(b_seq)
  );

  always #5 clk = ~clk;

  // Write capture; a write must never follow a cycle with fifo_full high.
  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      wq_a.push_back(a_wdata);
      if (prev_full) viol_a++;
    end
    if (b_wr === 1'b1) begin
      wq_b.push_back(b_wdata);
      if (prev_full) viol_b++;
    end
    prev_full = fifo_full;
  end

  // Payload word built from samples k (I=k, Q=k+0x80) and k+1.
  function automatic logic [31:0] pw(input int k);
    logic [7:0] i0, q0, i1, q1;
    i0 = 8'(k);
    q0 = 8'(k + 128);
    i1 = 8'(k + 1);
    q1 = 8'(k + 129);
    return {q1, i1, q0, i0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_i     = 8'h00;
    sample_q     = 8'h00;
    fifo_full    = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wq_a.delete();
    wq_b.delete();
    viol_a = 0;
    viol_b = 0;
  endtask

  // Cycle c: enable high outside [en_lo,en_hi], sample k=c-1 in [s_first,s_last], full in [full_lo,full_hi].
  task automatic run_stream(input int ncyc, input int s_first, input int s_last,
                            input int full_lo, input int full_hi,
                            input int en_lo, input int en_hi);
    for (int c = 0; c < ncyc; c++) begin
      enable       = !(c >= en_lo && c <= en_hi);
      sample_valid = (c >= s_first && c <= s_last);
      sample_i     = 8'(c - 1);
      sample_q     = 8'(c - 1 + 128);
      fifo_full    = (c >= full_lo && c <= full_hi);
      tick();
    end
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (a_wr !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_a got %b want 0", a_wr); end
    n_tests++; if (a_wdata !== 32'h0)  begin n_fail++; $display("FAIL reset_wdata_a got %h want 0", a_wdata); end
    n_tests++; if (a_drop !== 16'h0)   begin n_fail++; $display("FAIL reset_drop_a got %h want 0", a_drop); end
    n_tests++; if (a_seq !== 16'h0)    begin n_fail++; $display("FAIL reset_seq_a got %h want 0", a_seq); end
    n_tests++; if (b_wr !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_b got %b want 0", b_wr); end
    n_tests++; if (b_seq !== 16'h0)    begin n_fail++; $display("FAIL reset_seq_b got %h want 0", b_seq); end
  endtask

  task automatic test_basic_packing();
    logic [31:0] exp_w[6];
    exp_w = '{32'hA5A55A5A, 32'h00000000, 32'h81018000, 32'h83038202, 32'h85058404, 32'h87078606};
    do_reset();
    run_stream(14, 1, 8, -1, -2, -1, -2);
    n_tests++; if (wq_a.size() < 6) begin n_fail++; $display("FAIL basic_count got %0d want >=6", wq_a.size()); end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (wq_a[i] !== exp_w[i]) begin n_fail++; $display("FAIL basic_word%0d got %h want %h", i, wq_a[i], exp_w[i]); end
    end
    n_tests++; if (a_drop !== 16'h0) begin n_fail++; $display("FAIL basic_drop got %h want 0", a_drop); end
    n_tests++; if (a_seq !== 16'h1)  begin n_fail++; $display("FAIL basic_seq got %h want 1", a_seq); end
  endtask

  task automatic test_three_frames();
    do_reset();
    run_stream(32, 1, 24, -1, -2, -1, -2);
    n_tests++; if (wq_a.size() < 18) begin n_fail++; $display("FAIL frames_count got %0d want >=18", wq_a.size()); end
    for (int f = 0; f < 3; f++) begin
      n_tests++;
      if (wq_a[6*f] !== SYNC) begin n_fail++; $display("FAIL frames_sync%0d got %h want %h", f, wq_a[6*f], SYNC); end
      n_tests++;
      if (wq_a[6*f+1] !== {16'(f), 16'h0000}) begin
        n_fail++; $display("FAIL frames_hdr%0d got %h want %h", f, wq_a[6*f+1], {16'(f), 16'h0000});
      end
      for (int j = 0; j < 4; j++) begin
        n_tests++;
        if (wq_a[6*f+2+j] !== pw(8*f + 2*j)) begin
          n_fail++; $display("FAIL frames_pay%0d_%0d got %h want %h", f, j, wq_a[6*f+2+j], pw(8*f + 2*j));
        end
      end
    end
    n_tests++; if (a_seq !== 16'h3) begin n_fail++; $display("FAIL frames_seq got %h want 3", a_seq); end
  endtask

  task automatic test_payload_overflow();
    logic [31:0] exp_w[15];
    exp_w[0] = SYNC;
    exp_w[1] = 32'h0;
    exp_w[2] = pw(0);
    exp_w[3] = pw(2);
    exp_w[4] = pw(4);
    for (int j = 8; j < 16; j++) exp_w[j-3] = pw(2*j);
    exp_w[13] = SYNC;
    exp_w[14] = 32'h00010005;
    do_reset();
    run_stream(40, 1, 34, 8, 17, -1, -2);
    n_tests++; if (wq_b.size() < 15) begin n_fail++; $display("FAIL ovf_count got %0d want >=15", wq_b.size()); end
    for (int i = 0; i < 15; i++) begin
      n_tests++;
      if (wq_b[i] !== exp_w[i]) begin n_fail++; $display("FAIL ovf_word%0d got %h want %h", i, wq_b[i], exp_w[i]); end
    end
    n_tests++; if (viol_b != 0) begin n_fail++; $display("FAIL ovf_wr_while_full got %0d want 0", viol_b); end
  endtask

  task automatic test_header_stall();
    logic [31:0] exp_w[14];
    exp_w = '{SYNC, 32'h0, pw(0), pw(2), pw(4), pw(6),
              SYNC, 32'h00010002, pw(8), pw(16), pw(18), pw(20),
              SYNC, 32'h00020001};
    do_reset();
    run_stream(30, 1, 22, 9, 14, -1, -2);
    n_tests++; if (wq_a.size() != 14) begin n_fail++; $display("FAIL stall_count got %0d want 14", wq_a.size()); end
    for (int i = 0; i < 14; i++) begin
      n_tests++;
      if (wq_a[i] !== exp_w[i]) begin n_fail++; $display("FAIL stall_word%0d got %h want %h", i, wq_a[i], exp_w[i]); end
    end
    n_tests++; if (viol_a != 0) begin n_fail++; $display("FAIL stall_wr_while_full got %0d want 0", viol_a); end
  endtask

  task automatic test_enable_toggle();
    logic [31:0] exp_w[8];
    exp_w = '{SYNC, 32'h0, pw(0), pw(2), pw(4), SYNC, 32'h00010000, pw(12)};
    do_reset();
    run_stream(20, 1, 14, -1, -2, 8, 11);
    n_tests++; if (wq_a.size() != 8) begin n_fail++; $display("FAIL enable_count got %0d want 8", wq_a.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (wq_a[i] !== exp_w[i]) begin n_fail++; $display("FAIL enable_word%0d got %h want %h", i, wq_a[i], exp_w[i]); end
    end
    n_tests++; if (a_seq !== 16'h1) begin n_fail++; $display("FAIL enable_seq got %h want 1", a_seq); end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_stream(12, 1, 11, -1, -2, -1, -2);
    enable       = 1'b1;
    sample_valid = 1'b1;
    n_tests++; if (a_wr !== 1'b1)    begin n_fail++; $display("FAIL areset_pre_wr got %b want 1", a_wr); end
    n_tests++; if (a_wdata !== pw(8)) begin n_fail++; $display("FAIL areset_pre_data got %h want %h", a_wdata, pw(8)); end
    n_tests++; if (a_seq !== 16'h1)  begin n_fail++; $display("FAIL areset_pre_seq got %h want 1", a_seq); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (a_wr !== 1'b0)     begin n_fail++; $display("FAIL areset_wr got %b want 0", a_wr); end
    n_tests++; if (a_wdata !== 32'h0) begin n_fail++; $display("FAIL areset_data got %h want 0", a_wdata); end
    n_tests++; if (a_seq !== 16'h0)   begin n_fail++; $display("FAIL areset_seq got %h want 0", a_seq); end
    do_reset();
    run_stream(6, 1, 5, -1, -2, -1, -2);
    n_tests++; if (wq_a.size() < 2)  begin n_fail++; $display("FAIL areset_count got %0d want >=2", wq_a.size()); end
    n_tests++; if (wq_a[0] !== SYNC) begin n_fail++; $display("FAIL areset_sync got %h want %h", wq_a[0], SYNC); end
    n_tests++; if (wq_a[1] !== 32'h0) begin n_fail++; $display("FAIL areset_hdr got %h want 0", wq_a[1]); end
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_i     = 8'h00;
    sample_q     = 8'h00;
    fifo_full    = 1'b0;
    #2;
    test_reset();
    test_basic_packing();
    test_three_frames();
    test_payload_overflow();
    test_header_stall();
    test_enable_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
